// File: rtl/fp_multiplier_pipelined_pkg.sv
// fpu_pkg: IEEE-754 single-precision constants, operand classes and stage payloads shared by the FPU.
// Latency: none (types and a pure helper function only).
// Backpressure: none. The FP_MUL_RNE_EN macro, consumed by fp_round_pack, selects RNE rounding instead of truncation.
package fpu_pkg;

  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 23;
  localparam int MANT_W      = FRAC_W + 1;
  // The signed working exponent must hold ea+eb-bias+2 (up to 383) and down to -126.
  localparam int SEXP_W      = 10;
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_MAX  = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  typedef struct packed {
    logic               sign;
    fp_class_e          cls_a;
    fp_class_e          cls_b;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [MANT_W-1:0]  ma;
    logic [MANT_W-1:0]  mb;
  } s1_t;

  typedef struct packed {
    logic                sign;
    fp_class_e           cls_a;
    fp_class_e           cls_b;
    logic [SEXP_W-1:0]   exp;
    logic [2*MANT_W-1:0] prod;
  } s2_t;

  typedef struct packed {
    logic              sign;
    fp_class_e         cls_a;
    fp_class_e         cls_b;
    logic [SEXP_W-1:0] exp;
    logic [FRAC_W-1:0] mant;
    logic              guard;
    logic              sticky;
  } s3_t;

  // Denormals (exp=0, frac!=0) are deliberately folded into ZERO.
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    fp_class_e c;
    if (x[30:23] == '0)
      c = ZERO;
    else if (x[30:23] == EXP_W'(FP_EXP_MAX))
      c = (x[22:0] == '0) ? INF : NAN;
    else
      c = NORM;
    return c;
  endfunction

endpackage

// File: rtl/fp_multiplier_pipelined_if.sv
// fp_multiplier_pipelined_if: operand/result bundle between the issue logic and the FP multiplier.
// Latency: none (wires). Backpressure: the stall signal freezes the consumer.
// Ports: in_valid/a/b/in_tag/stall toward the multiplier; out_valid/result/out_tag/flag_* back to the master.
interface fp_multiplier_pipelined_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] in_tag;
  logic             stall;
  logic             out_valid;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             flag_ovf;
  logic             flag_unf;
  logic             flag_nv;

  modport master (
    output in_valid, a, b, in_tag, stall,
    input  out_valid, result, out_tag, flag_ovf, flag_unf, flag_nv
  );

  modport slave (
    input  in_valid, a, b, in_tag, stall,
    output out_valid, result, out_tag, flag_ovf, flag_unf, flag_nv
  );
endinterface

// File: rtl/fp_multiplier_pipelined_round_pack.sv
// fp_round_pack: round a normalised product, renormalise on carry, saturate and pack to IEEE single.
// Latency: combinational; the parent registers the outputs.
// Backpressure: none. FP_MUL_RNE_EN defined gives round-to-nearest-even, undefined gives truncation.
// Ports: i_sign/i_exp/i_mant/i_guard/i_sticky in; o_result/o_ovf/o_unf out.
module fp_round_pack
  import fpu_pkg::*;
(
  input  logic              i_sign,
  input  logic [SEXP_W-1:0] i_exp,
  input  logic [FRAC_W-1:0] i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [31:0]       o_result,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam logic signed [SEXP_W-1:0] EXP_MAX_S = SEXP_W'(FP_EXP_MAX);

  logic                     w_inc;
  logic [FRAC_W:0]          w_sum;
  logic signed [SEXP_W-1:0] w_exp;

`ifdef FP_MUL_RNE_EN
  assign w_inc = i_guard & (i_sticky | i_mant[0]);
`else
  // Truncation keeps the divider's round-toward-zero behaviour.
  logic w_unused_rnd;
  assign w_unused_rnd = i_guard ^ i_sticky;
  assign w_inc        = 1'b0;
`endif

  assign w_sum = {1'b0, i_mant} + {{FRAC_W{1'b0}}, w_inc};
  // On carry-out the fraction bits are already all zero: 1.111..1 + ulp = 10.000..0.
  assign w_exp = i_exp + SEXP_W'(w_sum[FRAC_W]);

  always_comb begin
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    o_result = {i_sign, w_exp[EXP_W-1:0], w_sum[FRAC_W-1:0]};
    if (w_exp >= EXP_MAX_S) begin
      o_ovf    = 1'b1;
      o_result = {i_sign, 8'hFF, 23'b0};
    end else if (w_exp <= 0) begin
      o_unf    = 1'b1;
      o_result = {i_sign, 31'b0};
    end
  end

endmodule

// File: rtl/fp_multiplier_pipelined.sv
// fp_multiplier_pipelined: 4-stage IEEE-754 single multiplier (unpack, multiply, normalise, round/pack).
// Latency: 4 cycles, throughput 1/cycle; tag and flags travel with each result.
// Backpressure: stall=1 freezes every stage including outputs; inputs are not captured while stalled.
// Ports: clk, rst_n (async, active-high), bus (slave modport of fp_multiplier_pipelined_if).
// Rounding selected by macro FP_MUL_RNE_EN (see fp_round_pack).
module fp_multiplier_pipelined
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fp_multiplier_pipelined_if.slave bus
);

  logic             r_s1_vld, r_s2_vld, r_s3_vld;
  s1_t              r_s1;
  s2_t              r_s2;
  s3_t              r_s3;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;

  logic             r_out_valid;
  logic [31:0]      r_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_flag_ovf, r_flag_unf, r_flag_nv;

  s1_t         w_s1;
  s2_t         w_s2;
  s3_t         w_s3;
  logic [31:0] w_rp_result;
  logic        w_rp_ovf, w_rp_unf;
  logic [31:0] w_result;
  logic        w_ovf, w_unf, w_nv;

  // S1: unpack and classify.
  always_comb begin
    w_s1       = '0;
    w_s1.sign  = bus.a[31] ^ bus.b[31];
    w_s1.cls_a = fp_classify(bus.a);
    w_s1.cls_b = fp_classify(bus.b);
    w_s1.ea    = bus.a[30:23];
    w_s1.eb    = bus.b[30:23];
    w_s1.ma    = {1'b1, bus.a[22:0]};
    w_s1.mb    = {1'b1, bus.b[22:0]};
  end

  // S2: mantissa product and biased exponent sum.
  always_comb begin
    w_s2       = '0;
    w_s2.sign  = r_s1.sign;
    w_s2.cls_a = r_s1.cls_a;
    w_s2.cls_b = r_s1.cls_b;
    w_s2.exp   = SEXP_W'(r_s1.ea) + SEXP_W'(r_s1.eb) - SEXP_W'(FP_EXP_BIAS);
    w_s2.prod  = (2*MANT_W)'(r_s1.ma) * (2*MANT_W)'(r_s1.mb);
  end

  // S3: the product of two [1,2) mantissas lies in [1,4); at most one shift is needed.
  always_comb begin
    w_s3       = '0;
    w_s3.sign  = r_s2.sign;
    w_s3.cls_a = r_s2.cls_a;
    w_s3.cls_b = r_s2.cls_b;
    if (r_s2.prod[47]) begin
      w_s3.mant   = r_s2.prod[46:24];
      w_s3.guard  = r_s2.prod[23];
      w_s3.sticky = |r_s2.prod[22:0];
      w_s3.exp    = r_s2.exp + SEXP_W'(1);
    end else begin
      w_s3.mant   = r_s2.prod[45:23];
      w_s3.guard  = r_s2.prod[22];
      w_s3.sticky = |r_s2.prod[21:0];
      w_s3.exp    = r_s2.exp;
    end
  end

  // S4: round/pack the finite path, then let special operands override it.
  fp_round_pack u_round_pack (
    .i_sign   (r_s3.sign),
    .i_exp    (r_s3.exp),
    .i_mant   (r_s3.mant),
    .i_guard  (r_s3.guard),
    .i_sticky (r_s3.sticky),
    .o_result (w_rp_result),
    .o_ovf    (w_rp_ovf),
    .o_unf    (w_rp_unf)
  );

  always_comb begin
    w_result = w_rp_result;
    w_ovf    = w_rp_ovf;
    w_unf    = w_rp_unf;
    w_nv     = 1'b0;
    if ((r_s3.cls_a == NAN) || (r_s3.cls_b == NAN) ||
        ((r_s3.cls_a == INF) && (r_s3.cls_b == ZERO)) ||
        ((r_s3.cls_a == ZERO) && (r_s3.cls_b == INF))) begin
      w_result = FP_QNAN;
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
      w_nv     = 1'b1;
    end else if ((r_s3.cls_a == INF) || (r_s3.cls_b == INF)) begin
      w_result = {r_s3.sign, 8'hFF, 23'b0};
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
    end else if ((r_s3.cls_a == ZERO) || (r_s3.cls_b == ZERO)) begin
      // An exact zero operand is not an underflow.
      w_result = {r_s3.sign, 31'b0};
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s3_vld    <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_s1_tag    <= '0;
      r_s2_tag    <= '0;
      r_s3_tag    <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_flag_ovf  <= 1'b0;
      r_flag_unf  <= 1'b0;
      r_flag_nv   <= 1'b0;
    end else if (!bus.stall) begin
      r_s1_vld    <= bus.in_valid;
      r_s1        <= w_s1;
      r_s1_tag    <= bus.in_tag;
      r_s2_vld    <= r_s1_vld;
      r_s2        <= w_s2;
      r_s2_tag    <= r_s1_tag;
      r_s3_vld    <= r_s2_vld;
      r_s3        <= w_s3;
      r_s3_tag    <= r_s2_tag;
      r_out_valid <= r_s3_vld;
      r_result    <= w_result;
      r_out_tag   <= r_s3_tag;
      // Flags are qualified so bubbles never report stale exceptions.
      r_flag_ovf  <= r_s3_vld & w_ovf;
      r_flag_unf  <= r_s3_vld & w_unf;
      r_flag_nv   <= r_s3_vld & w_nv;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.out_tag   = r_out_tag;
  assign bus.flag_ovf  = r_flag_ovf;
  assign bus.flag_unf  = r_flag_unf;
  assign bus.flag_nv   = r_flag_nv;

endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// tb_fp_multiplier_pipelined: directed vectors plus randomized valid/stall traffic against a value-level model.
// Expected results are queued with the count of non-stalled edges at acceptance; each output is due 4 such edges later.
// Ports: none (top-level bench).
module tb_fp_multiplier_pipelined;

  localparam int TAG_W = 5;

  logic clk;
  logic rst_n;

  fp_multiplier_pipelined_if #(.TAG_W(TAG_W)) bus ();

  fp_multiplier_pipelined #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flg;   // {ovf, unf, nv}
  } exp_t;

  exp_t q[$];
  int   act_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
  endtask

  // Value-level reference: the exact integer product of the significands is reduced to
  // 24 significant bits and rounded by comparing the discarded remainder with half an ulp.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f);
    int ea, eb, e, sh;
    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned p, m, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    f = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 32'h7FC00000; f = 3'b001;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'b0};
    end else begin
      p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      m  = p;
      sh = 0;
      while (m >= 64'd16777216) begin m = m >> 1; sh++; end
      // value = m * 2^(e-150), with m in [2^23, 2^24)
      e    = ea + eb - 127 + (sh - 23);
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
      if ((rem > half) || ((rem == half) && m[0])) m = m + 1;
      if (m == 64'd16777216) begin m = m >> 1; e = e + 1; end
`endif
      if (e >= 255) begin
        r = {s, 8'hFF, 23'b0}; f = 3'b100;
      end else if (e <= 0) begin
        r = {s, 31'b0}; f = 3'b010;
      end else begin
        r = {s, 8'(e), m[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] fr;
    int k;
    k  = $urandom_range(0, 15);
    fr = 23'($urandom);
    if ($urandom_range(0, 7) == 0) fr = 23'h7FFFFF;
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'd255; fr = 23'd0; end
      2:       begin e = 8'd255; fr = fr | 23'd1; end
      3:       e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 40));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, fr};
  endfunction

  task automatic check_outputs();
    while ((q.size() > 0) && (q[0].n + 4 < act_cnt)) void'(q.pop_front());
    if ((q.size() > 0) && (q[0].n + 4 == act_cnt)) begin
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("result", bus.result, q[0].res);
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      chk("flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_nv}), 32'(q[0].flg));
    end else begin
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_nv}), 32'd0);
    end
  endtask

  // One clock: drive at the falling edge, account at the rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic [31:0] va, input logic [31:0] vb,
                      input logic [TAG_W-1:0] t, input logic st,
                      input logic use_fix, input logic [31:0] fix_res, input logic [2:0] fix_flg);
    exp_t e;
    logic [31:0] r;
    logic [2:0]  f;
    bus.in_valid = v;
    bus.a        = va;
    bus.b        = vb;
    bus.in_tag   = t;
    bus.stall    = st;
    @(posedge clk);
    if (v && !st) begin
      if (use_fix) begin r = fix_res; f = fix_flg; end
      else ref_mul(va, vb, r, f);
      e.n = act_cnt; e.res = r; e.tag = t; e.flg = f;
      q.push_back(e);
    end
    if (!st) act_cnt++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0, 32'd0, 3'd0);
  endtask

`ifdef FP_MUL_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC00001;
`endif

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.in_tag   = '0;
    bus.stall    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_nv}), 32'd0);
    rst_n = 1'b0;

    // Single operation and its latency.
    step(1'b1, 32'h40000000, 32'h40400000, 5'd3, 1'b0, 1'b1, 32'h40C00000, 3'b000);
    idle(5);

    // Back-to-back stream with a 2-cycle stall (inputs offered during the stall are ignored).
    step(1'b1, 32'h3FC00000, 32'h3FC00000, 5'd1, 1'b0, 1'b1, 32'h40100000, 3'b000);
    step(1'b1, 32'hBF800000, 32'h40000000, 5'd2, 1'b0, 1'b1, 32'hC0000000, 3'b000);
    step(1'b1, 32'h7F000000, 32'h40000000, 5'd4, 1'b0, 1'b1, 32'h7F800000, 3'b100);
    step(1'b1, 32'h00800000, 32'h00800000, 5'd5, 1'b0, 1'b1, 32'h00000000, 3'b010);
    step(1'b1, 32'h7FC00000, 32'h3F800000, 5'd9, 1'b1, 1'b1, 32'h7FC00000, 3'b001);
    step(1'b1, 32'h7FC00000, 32'h3F800000, 5'd9, 1'b1, 1'b1, 32'h7FC00000, 3'b001);
    step(1'b1, 32'h7F800000, 32'h00000000, 5'd6, 1'b0, 1'b1, 32'h7FC00000, 3'b001);
    step(1'b1, 32'hFF800000, 32'h40000000, 5'd7, 1'b0, 1'b1, 32'hFF800000, 3'b000);
    step(1'b1, 32'h3F800001, 32'h3FC00000, 5'd8, 1'b0, 1'b1, RND_EXP, 3'b000);
    step(1'b1, 32'h7FC00001, 32'h00000000, 5'd10, 1'b0, 1'b1, 32'h7FC00000, 3'b001);
    idle(6);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 75), rand_op(), rand_op(), TAG_W'($urandom),
           1'($urandom_range(0, 99) < 15), 1'b0, 32'd0, 3'd0);
    end
    idle(6);

    // Asynchronous reset with operations in flight and a result on the outputs.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rand_op(), rand_op(), TAG_W'(i + 11), 1'b0, 1'b0, 32'd0, 3'd0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    chk("post_rst_tag", 32'(bus.out_tag), 32'd0);
    idle(6);
    step(1'b1, 32'h40000000, 32'h40400000, 5'd21, 1'b0, 1'b1, 32'h40C00000, 3'b000);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_multiplier_pipelined.md
Name: fp_multiplier_pipelined

Overview:
- Pipelined IEEE-754 single-precision multiplier; companion to the FPU's pipelined divider and shares its operand/result format.
- Accepts one operand pair per cycle under valid/stall control and returns the product after a fixed 4-cycle latency.
- Carries an opaque tag so the integer-core writeback logic can match each result to its destination register.
- Flags are reported per result.

Parameters:
TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand pair on a/b/in_tag is valid this cycle.
a  input  32  multiplicand, IEEE-754 single.
b  input  32  multiplier, IEEE-754 single.
in_tag  input  TAG_W  tag carried alongside the operation.
stall  input  1  when 1, all pipeline registers hold; inputs are ignored.
out_valid  output  1  result/out_tag/flags valid this cycle.
result  output  32  product, IEEE-754 single.
out_tag  output  TAG_W  tag of the delivered result.
flag_ovf  output  1  overflow: result forced to ±infinity.
flag_unf  output  1  underflow: result flushed to ±0.
flag_nv  output  1  invalid: 0×inf, or any NaN operand.

Behaviour:
- Reset (asynchronous, mid-operation included): all stage valids, out_valid, result, out_tag and flags go to 0. In-flight operations are discarded.
- Pipeline: S1 unpack/classify → S2 24×24 mantissa multiply → S3 normalise → S4 round/pack (registered outputs).
- Latency: an operation accepted at edge N (in_valid=1, stall=0) appears with out_valid=1 after edge N+4. Throughput is 1/cycle.
- Stall: stall=1 freezes every stage, including the outputs; out_valid, result and flags hold their values.
- An input presented during a stall cycle is not captured.
- A bubble (in_valid=0) propagates as valid=0. Datapath registers of invalid stages may hold stale data, but out_valid must be 0.
- S1:
  - sign = a[31]^b[31].
  - Classify each operand as zero (exp=0, denormals flushed to zero), inf (exp=255, frac=0) or NaN (exp=255, frac≠0).
  - Mantissa = {1, frac} for normal operands.
- S2:
  - 48-bit product of the 24-bit mantissas.
  - 10-bit signed exponent = ea + eb − 127.
- S3:
  - If prod[47]=1: mantissa = prod[46:24], guard = prod[23], sticky = |prod[22:0]; exponent += 1.
  - Otherwise: mantissa = prod[45:23], guard = prod[22], sticky = |prod[21:0].
- S4 rounding:
  - Apply rounding as defined under Optional Feature.
  - A mantissa carry-out renormalises the result (mantissa = 0) and increments the exponent.
- S4 range checks:
  - exponent ≥ 255 → {sign, 8'hFF, 0}, flag_ovf=1.
  - exponent ≤ 0 → {sign, 31'b0}, flag_unf=1.
- Special cases, with priority NaN > invalid > inf > zero:
  - Any NaN operand → 32'h7FC00000, flag_nv=1.
  - inf×0 → 32'h7FC00000, flag_nv=1.
  - inf×finite-nonzero or inf×inf → {sign, 8'hFF, 0}; no flag.
  - Any zero operand → {sign, 31'b0}; flag_unf=0.
- Flags are valid only with out_valid=1 and are 0 otherwise.

Optional Feature:
- FP_MUL_RNE_EN defined: round-to-nearest-even. Increment when guard & (sticky | lsb).
- FP_MUL_RNE_EN undefined: truncation (round toward zero); guard and sticky are ignored. This matches the divider's truncating behaviour.

Decomposition:
- Shared package fpu_pkg:
  - Constants FP_EXP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000.
  - Field widths EXP_W=8, FRAC_W=23.
  - Operand-class encoding (ZERO/NORM/INF/NAN).
- One sub-module fp_round_pack: S4 rounding, carry renormalisation, overflow/underflow saturation and packing. Combinational, registered by the parent.

Test Plan:
- 0x40000000 × 0x40400000, tag 3 → 0x40C00000 four cycles later, out_tag 3, all flags 0.
- Back-to-back stream of 0x3FC00000×0x3FC00000 then 0xBF800000×0x40000000 → 0x40100000 then 0xC0000000 on consecutive cycles; assert stall for 2 cycles mid-stream → outputs hold and no result is lost or duplicated.
- 0x3F800001 × 0x3FC00000 → 0x3FC00002 with FP_MUL_RNE_EN, 0x3FC00001 without.
- 0x7F000000 × 0x40000000 → 0x7F800000, flag_ovf=1; 0x00800000 × 0x00800000 → 0x00000000, flag_unf=1.
- 0x7F800000 × 0x00000000 → 0x7FC00000, flag_nv=1; 0xFF800000 × 0x40000000 → 0xFF800000, no flags.
- Assert rst_n for 1 cycle with 3 operations in flight → out_valid=0 on every following cycle until a new input is accepted.
